// File: rtl/os_msg_display_pkg.sv
// os_msg_display_pkg: shared OS message entry, display FSM states and message codes
package os_msg_display_pkg;
  typedef struct packed {
    logic [4:0] pid;
    logic [4:0] code;
  } msg_entry_t;
  typedef enum logic [1:0] {IDLE, SHOW, GAP} disp_state_t;
  localparam logic [4:0] MSG_NONE      = 5'd0;
  localparam logic [4:0] MSG_BIOS_BOOT = 5'd1;
  localparam logic [4:0] MSG_BIOS_OK   = 5'd2;
  localparam logic [4:0] MSG_KERN_LOAD = 5'd3;
  localparam logic [4:0] MSG_KERN_OK   = 5'd4;
  localparam logic [4:0] MSG_PROC_NEW  = 5'd5;
  localparam logic [4:0] MSG_PROC_EXIT = 5'd6;
  localparam logic [4:0] MSG_SYSCALL   = 5'd7;
  localparam logic [4:0] MSG_FAULT     = 5'd31;
endpackage

// File: rtl/os_msg_display_msg_fifo.sv
// msg_fifo: DEPTH x 10-bit synchronous FIFO with clear; push on full is accepted only alongside a pop
module msg_fifo
  import os_msg_display_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  msg_entry_t               din,
  output msg_entry_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  msg_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full  = count[AW];
  assign empty = count == '0;
  assign wr_en = push && !clear && (!full || pop);
  assign rd_en = pop && !clear && !empty;
  assign dout  = mem[rd_ptr];
  // pointer and occupancy tracking; clear flushes without touching storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
  // entry storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/os_msg_display.sv
// os_msg_display: queues PID-tagged messages and shows each for a fixed dwell followed by a blank gap
module os_msg_display
  import os_msg_display_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msg_sign,
  input  logic [4:0]             msg_code,
  input  logic [4:0]             pid,
  input  logic                   clear,
  output logic                   disp_valid,
  output logic [4:0]             disp_code,
  output logic [4:0]             disp_pid,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow,
  output logic                   busy
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  disp_state_t state;
  logic [CW-1:0] cnt;
  msg_entry_t din, head;
  logic full, empty, done, pop;
  assign din  = {pid, msg_code};
  assign done = cnt == '0;
  assign pop  = !clear && !empty &&
                (state == IDLE || (done && (state == GAP || (state == SHOW && GAP_CYCLES == 0))));
  assign busy = state != IDLE || !empty;
  msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (msg_sign),
    .pop   (pop),
    .clear (clear),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );
  // display FSM: one shared down-counter times both the hold and the gap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      disp_valid <= 1'b0;
      disp_code  <= '0;
      disp_pid   <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      cnt        <= '0;
      disp_valid <= 1'b0;
      disp_code  <= '0;
      disp_pid   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (msg_sign && full && !pop) overflow <= 1'b1;
      if (pop) begin
        state      <= SHOW;
        cnt        <= HOLD_LD;
        disp_valid <= 1'b1;
        disp_code  <= head.code;
        disp_pid   <= head.pid;
      end else if (state != IDLE) begin
        if (!done) cnt <= cnt - CW'(1);
        else begin
          state      <= (state == SHOW && GAP_CYCLES > 0) ? GAP : IDLE;
          cnt        <= state == SHOW ? GAP_LD : '0;
          disp_valid <= 1'b0;
          disp_code  <= '0;
          disp_pid   <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_os_msg_display.sv
// tb_os_msg_display: directed checks of queuing, dwell/gap timing, overflow, clear and reset
module tb_os_msg_display;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic msg_sign = 1'b0;
  logic [4:0] msg_code = '0;
  logic [4:0] pid = '0;
  logic clear = 1'b0;
  logic disp_valid;
  logic [4:0] disp_code, disp_pid;
  logic [2:0] pending;
  logic overflow, busy;
  int n_chk = 0;
  int n_err = 0;

  os_msg_display #(.DEPTH(4), .HOLD_CYCLES(3), .GAP_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .msg_sign   (msg_sign),
    .msg_code   (msg_code),
    .pid        (pid),
    .clear      (clear),
    .disp_valid (disp_valid),
    .disp_code  (disp_code),
    .disp_pid   (disp_pid),
    .pending    (pending),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [4:0] c, input logic [4:0] p, input logic clr);
    msg_sign = s;
    msg_code = c;
    pid = p;
    clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic push(input logic [4:0] c, input logic [4:0] p);
    step(1'b1, c, p, 1'b0);
  endtask

  // next edge starts showing (code,pid); 3 visible cycles then 2 blank ones
  task automatic show_seq(input logic [4:0] c, input logic [4:0] p);
    idle();
    check("show_valid", disp_valid, 1);
    check("show_code", disp_code, c);
    check("show_pid", disp_pid, p);
    idle();
    check("hold2_valid", disp_valid, 1);
    idle();
    check("hold3_valid", disp_valid, 1);
    idle();
    check("gap1_valid", disp_valid, 0);
    check("gap1_code", disp_code, 0);
    idle();
    check("gap2_valid", disp_valid, 0);
  endtask

  initial begin
    #12;
    check("rst_valid", disp_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    idle();
    // single message
    push(5'd5, 5'd2);
    check("single_pending", pending, 1);
    check("single_pre_valid", disp_valid, 0);
    show_seq(5'd5, 5'd2);
    idle();
    check("single_busy", busy, 0);
    // burst of four
    push(5'd1, 5'd3);
    push(5'd2, 5'd3);
    check("burst_first", disp_code, 1);
    push(5'd3, 5'd3);
    push(5'd4, 5'd3);
    check("burst_pending", pending, 3);
    check("burst_first_hold", disp_code, 1);
    idle();
    check("burst_gap", disp_valid, 0);
    idle();
    show_seq(5'd2, 5'd3);
    show_seq(5'd3, 5'd3);
    show_seq(5'd4, 5'd3);
    idle();
    check("burst_busy", busy, 0);
    check("burst_ovf", overflow, 0);
    // overflow: six back-to-back pushes
    for (int i = 1; i <= 6; i++) push(5'(i), 5'd7);
    check("ovf_flag", overflow, 1);
    check("ovf_pending", pending, 4);
    show_seq(5'd2, 5'd7);
    show_seq(5'd3, 5'd7);
    show_seq(5'd4, 5'd7);
    show_seq(5'd5, 5'd7);
    idle();
    check("ovf_drained_busy", busy, 0);
    check("ovf_sticky", overflow, 1);
    step(1'b0, 5'd0, 5'd0, 1'b1);
    check("ovf_cleared", overflow, 0);
    // full FIFO: push coinciding with the pop at the end of a gap
    for (int i = 1; i <= 5; i++) push(5'(i), 5'd1);
    check("full_pending", pending, 4);
    idle();
    push(5'd9, 5'd1);
    check("full_pp_pending", pending, 4);
    check("full_pp_ovf", overflow, 0);
    check("full_pp_code", disp_code, 2);
    step(1'b0, 5'd0, 5'd0, 1'b1);
    // clear mid-SHOW with a push in the same cycle
    push(5'd1, 5'd4);
    push(5'd2, 5'd4);
    push(5'd3, 5'd4);
    check("clr_pre_pending", pending, 2);
    check("clr_pre_valid", disp_valid, 1);
    step(1'b1, 5'd7, 5'd4, 1'b1);
    check("clr_valid", disp_valid, 0);
    check("clr_pending", pending, 0);
    check("clr_ovf", overflow, 0);
    check("clr_busy", busy, 0);
    idle();
    idle();
    check("clr_never_shown", disp_valid, 0);
    // asynchronous reset mid-GAP
    push(5'd5, 5'd6);
    for (int i = 0; i < 4; i++) idle();
    check("prerst_gap_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", disp_valid, 0);
    check("arst_code", disp_code, 0);
    check("arst_pending", pending, 0);
    check("arst_busy", busy, 0);
    #1 reset = 1'b1;
    push(5'd6, 5'd4);
    check("post_rst_pending", pending, 1);
    idle();
    check("post_rst_valid", disp_valid, 1);
    check("post_rst_code", disp_code, 6);
    check("post_rst_pid", disp_pid, 4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
